// File: rtl/parity_ctrl_pkg.sv
// Shared definitions for the parity batch controller: word width and FSM state encoding.
package parity_ctrl_pkg;

    localparam int WORD_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/even_parity_checker.sv
// Even-parity checker: check is 1 when data word plus parity bit has odd weight.
module even_parity_checker
    import parity_ctrl_pkg::*;
(
    input  logic [WORD_W-1:0] in,
    input  logic              parity,
    output logic              check
);

    assign check = ^{in, parity};

endmodule

// File: rtl/parity_batch_controller.sv
// Runs a batch of N_WORDS parity-protected words through the checker over a
// valid/ready handshake, counting errors and reporting a pass/fail verdict.
module parity_batch_controller
    import parity_ctrl_pkg::*;
#(
    parameter int N_WORDS = 8,
    parameter int ERR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in,
    input  logic              parity,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              last_err,
    output logic [ERR_W-1:0]  err_count
);

    localparam int                 CNT_W    = $clog2(N_WORDS + 1);
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(N_WORDS - 1);
    localparam logic [ERR_W-1:0]   ERR_MAX  = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             last_err_q, last_err_d;
    logic             pass_q, pass_d;
    logic             check;

    even_parity_checker u_checker (
        .in     (in),
        .parity (parity),
        .check  (check)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            err_q      <= '0;
            last_err_q <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            last_err_q <= last_err_d;
            pass_q     <= pass_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        last_err_d = last_err_q;
        pass_d     = pass_q;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    cnt_d      = '0;
                    err_d      = '0;
                    last_err_d = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = !abort;
                // Abort takes priority: a word offered alongside abort is dropped.
                if (abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (in_valid) begin
                    cnt_d      = cnt_q + 1'b1;
                    last_err_d = check;
                    if (check && (err_q != ERR_MAX)) begin
                        err_d = err_q + 1'b1;
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                pass_d  = (err_q == '0);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pass      = pass_q;
    assign last_err  = last_err_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_parity_batch_controller.sv
// Scoreboard bench for parity_batch_controller (N_WORDS=4, ERR_W=2).
module tb_parity_batch_controller;

    localparam int NW   = 4;
    localparam int EW   = 2;
    localparam int EMAX = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [2:0]    din = 3'd0;
    logic          par = 1'b0;
    logic          in_ready, busy, done, pass, last_err;
    logic [EW-1:0] err_count;

    parity_batch_controller #(.N_WORDS(NW), .ERR_W(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .parity    (par),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .last_err  (last_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct { int e; int cnt; } acc_t;
    typedef struct { int cnt; int ps; } bat_t;

    acc_t       acc_q[$];
    bat_t       bat_q[$];
    logic [3:0] word_q[$];
    acc_t       a_m;
    bat_t       b_m;
    int         total = 0;
    int         bad = 0;
    int         done_seen = 0;
    int         done_exp = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: an accept seen before an edge is checked on the following negedge.
    bit pend_acc = 0, pend_pass = 0, prev_done = 0;
    int pass_exp = 0;
    always @(negedge clk) begin
        if (rst) begin
            pend_acc  = 0;
            pend_pass = 0;
            prev_done = 0;
        end else begin
            if (pend_acc) begin
                pend_acc = 0;
                if (acc_q.size() == 0) chk("acc_queue_empty", 1, 0);
                else begin
                    a_m = acc_q.pop_front();
                    chk("last_err", int'(last_err), a_m.e);
                    chk("err_count", int'(err_count), a_m.cnt);
                end
            end
            if (pend_pass) begin
                pend_pass = 0;
                chk("pass", int'(pass), pass_exp);
            end
            if (done) begin
                done_seen++;
                chk("done_width", int'(prev_done), 0);
                if (bat_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    b_m = bat_q.pop_front();
                    chk("done_err_count", int'(err_count), b_m.cnt);
                    pass_exp  = b_m.ps;
                    pend_pass = 1;
                end
            end
            prev_done = done;
            if (in_valid && in_ready) pend_acc = 1;
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_err_clr", int'(err_count), 0);
        chk("start_last_err_clr", int'(last_err), 0);
        chk("start_pass_clr", int'(pass), 0);
    endtask

    // throttle: 0 = always valid, 1 = pattern 1,0,0, 2 = random
    task automatic run_batch(input int throttle, input int abort_at, input int rst_at,
                             input bit start_mid, input bit start_done);
        int n, stop, errs, idx, cyc, e, last_e;
        bit acc;
        n = word_q.size();
        stop = n;
        errs = 0;
        last_e = 0;
        idx = 0;
        cyc = 0;
        if (abort_at >= 0) stop = abort_at;
        else if (rst_at >= 0) stop = rst_at;
        for (int i = 0; i < stop; i++) begin
            e = int'(^word_q[i]);
            errs = (errs + e > EMAX) ? EMAX : errs + e;
            last_e = e;
            acc_q.push_back('{e, errs});
        end
        if (stop == n) begin
            bat_q.push_back('{errs, (errs == 0) ? 1 : 0});
            done_exp++;
        end
        do_start();
        while (idx < stop) begin
            if (cyc > 200) begin
                chk("accept_timeout", idx, stop);
                break;
            end
            cyc++;
            case (throttle)
                1:       in_valid = (cyc % 3 == 1);
                2:       in_valid = ($urandom_range(0, 2) == 0);
                default: in_valid = 1'b1;
            endcase
            {din, par} = word_q[idx];
            start = start_mid && !in_valid && (idx == 1);
            #3 acc = in_valid && in_ready;
            @(posedge clk);
            #1 start = 1'b0;
            if (acc) idx++;
        end
        if (abort_at >= 0) begin
            in_valid = 1'b1;
            abort = 1'b1;
            {din, par} = word_q[stop];
            #1 chk("abort_in_ready", int'(in_ready), 0);
            @(posedge clk);
            #1 abort = 1'b0;
            in_valid = 1'b0;
            chk("abort_busy", int'(busy), 0);
            chk("abort_err_kept", int'(err_count), errs);
            chk("abort_last_err_kept", int'(last_err), last_e);
            chk("abort_pass", int'(pass), 0);
            @(posedge clk);
            #1;
        end else if (rst_at >= 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #2 rst = 1'b1;
            #1 chk("rst_busy", int'(busy), 0);
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_err_count", int'(err_count), 0);
            chk("rst_last_err", int'(last_err), 0);
            chk("rst_pass", int'(pass), 0);
            @(posedge clk);
            #1 rst = 1'b0;
        end else begin
            in_valid = 1'b0;
            if (start_done) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            chk("idle_after_done", int'(busy), 0);
            @(posedge clk);
            #1 chk("still_idle", int'(busy), 0);
        end
        word_q.delete();
    endtask

    initial begin
        #12;
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_pass", int'(pass), 0);
        chk("reset_last_err", int'(last_err), 0);
        chk("reset_err_count", int'(err_count), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // clean batch
        word_q = '{4'b0000, 4'b0011, 4'b0110, 4'b1111};
        run_batch(0, -1, -1, 0, 0);
        // two errors, alternating last_err
        word_q = '{4'b0010, 4'b0000, 4'b1101, 4'b1010};
        run_batch(0, -1, -1, 0, 0);
        // saturation, twice to confirm restart clears the counter
        for (int r = 0; r < 2; r++) begin
            word_q = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
            run_batch(0, -1, -1, 0, 0);
        end
        // abort after two accepted words
        for (int i = 0; i < NW; i++) word_q.push_back(4'($urandom_range(0, 15)));
        run_batch(0, 2, -1, 0, 0);
        // async reset mid-batch
        for (int i = 0; i < NW; i++) word_q.push_back(4'($urandom_range(0, 15)));
        run_batch(0, -1, 2, 0, 0);
        // start during RUN and during DONE ignored; throttled 1,0,0 source
        for (int i = 0; i < NW; i++) word_q.push_back(4'($urandom_range(0, 15)));
        run_batch(1, -1, -1, 1, 1);
        // random batches with random throttling
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < NW; i++) word_q.push_back(4'($urandom_range(0, 15)));
            run_batch(2, -1, -1, 0, 0);
        end

        @(posedge clk);
        #1;
        chk("done_count", done_seen, done_exp);
        chk("acc_queue_drained", acc_q.size(), 0);
        chk("batch_queue_drained", bat_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
